ysyx_23060332_wbu: RTL and testbench

- Write-back unit that drives the register file write port (waddr, wdata, reg_wen).
- Accepts completed instructions from the EXU over a valid/ready handshake.
- ALU results pass through with one cycle of latency.
- Loads wait for the LSU read response, then byte/halfword extraction and sign/zero extension are applied.
- Emits a one-cycle retire pulse per instruction for the simulation/difftest hooks.

---
 rtl/ysyx_23060332_wbu.sv | 156 +++++++++++++++
 tb/tb_ysyx_23060332_wbu.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060332_wbu.sv
// Write-back unit: drives the register file write port from EXU results
// and LSU load responses, with a retire pulse per instruction.
module ysyx_23060332_wbu #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [4:0]  ex_rd,
  input  logic        ex_wen,
  input  logic [31:0] ex_result,
  input  logic        ex_is_load,
  input  logic [2:0]  ex_load_fn,
  input  logic [1:0]  ex_addr_lo,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        mem_rready,
  output logic [4:0]  waddr,
  output logic [31:0] wdata,
  output logic        reg_wen,
  output logic        wb_done,
  output logic        err_misalign,
  output logic        err_timeout
);

  localparam logic S_IDLE = 1'b0;
  localparam logic S_WAIT = 1'b1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic             r_state;
  logic [4:0]       r_rd;
  logic             r_wen;
  logic [2:0]       r_fn;
  logic [1:0]       r_lo;
  logic [CNT_W-1:0] r_cnt;

  logic             w_accept;
  logic             w_bad;
  logic             w_hit;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [31:0]      w_ldata;

  assign ex_ready   = (r_state == S_IDLE);
  assign mem_rready = (r_state == S_WAIT);
  assign w_accept   = ex_valid & ex_ready;
  assign w_hit      = (r_cnt == CNT_LAST);
  assign w_half     = r_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  // Byte lane selected by the low address bits.
  always_comb begin
    w_byte = mem_rdata[7:0];
    unique case (r_lo)
      2'd0: w_byte = mem_rdata[7:0];
      2'd1: w_byte = mem_rdata[15:8];
      2'd2: w_byte = mem_rdata[23:16];
      2'd3: w_byte = mem_rdata[31:24];
    endcase
  end

  // Flag loads that are misaligned or use an unsupported funct3.
  always_comb begin
    w_bad = 1'b1;
    case (r_fn)
      3'b000:  w_bad = 1'b0;
      3'b100:  w_bad = 1'b0;
      3'b001:  w_bad = r_lo[0];
      3'b101:  w_bad = r_lo[0];
      3'b010:  w_bad = (r_lo != 2'd0);
      default: w_bad = 1'b1;
    endcase
  end

  // Extract and extend the loaded value.
  always_comb begin
    w_ldata = 32'd0;
    case (r_fn)
      3'b000:  w_ldata = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_ldata = {24'd0, w_byte};
      3'b001:  w_ldata = {{16{w_half[15]}}, w_half};
      3'b101:  w_ldata = {16'd0, w_half};
      3'b010:  w_ldata = mem_rdata;
      default: w_ldata = 32'd0;
    endcase
  end

  // Capture load context on acceptance; it is only read in WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd  <= 5'd0;
      r_wen <= 1'b0;
      r_fn  <= 3'd0;
      r_lo  <= 2'd0;
    end else if (w_accept && ex_is_load) begin
      r_rd  <= ex_rd;
      r_wen <= ex_wen;
      r_fn  <= ex_load_fn;
      r_lo  <= ex_addr_lo;
    end
  end

  // State machine, timeout counter, write port and sticky errors.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      waddr        <= 5'd0;
      wdata        <= 32'd0;
      reg_wen      <= 1'b0;
      wb_done      <= 1'b0;
      err_misalign <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      reg_wen <= 1'b0;
      wb_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (ex_is_load) begin
              r_cnt   <= '0;
              r_state <= S_WAIT;
            end else begin
              reg_wen <= ex_wen & (ex_rd != 5'd0);
              waddr   <= ex_rd;
              wdata   <= ex_result;
              wb_done <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            r_state <= S_IDLE;
            wb_done <= 1'b1;
            waddr   <= r_rd;
            if (w_bad) begin
              err_misalign <= 1'b1;
            end else begin
              reg_wen <= r_wen & (r_rd != 5'd0);
              wdata   <= w_ldata;
            end
          end else if (w_hit) begin
            r_state     <= S_IDLE;
            wb_done     <= 1'b1;
            err_timeout <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060332_wbu.sv
// Scoreboard bench for the write-back unit: expected writes are queued
// at issue and popped when wb_done pulses.
module tb_ysyx_23060332_wbu;

  typedef struct {
    logic        wen;
    logic [4:0]  a;
    logic [31:0] d;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic [4:0]  ex_rd;
  logic        ex_wen;
  logic [31:0] ex_result;
  logic        ex_is_load;
  logic [2:0]  ex_load_fn;
  logic [1:0]  ex_addr_lo;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_rready;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        reg_wen;
  logic        wb_done;
  logic        err_misalign;
  logic        err_timeout;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ysyx_23060332_wbu #(
    .TIMEOUT_CYCLES(8),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ex_valid(ex_valid),
    .ex_ready(ex_ready),
    .ex_rd(ex_rd),
    .ex_wen(ex_wen),
    .ex_result(ex_result),
    .ex_is_load(ex_is_load),
    .ex_load_fn(ex_load_fn),
    .ex_addr_lo(ex_addr_lo),
    .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata),
    .mem_rready(mem_rready),
    .waddr(waddr),
    .wdata(wdata),
    .reg_wen(reg_wen),
    .wb_done(wb_done),
    .err_misalign(err_misalign),
    .err_timeout(err_timeout)
  );

  function automatic logic [31:0] ld_model(input logic [2:0] fn,
                                           input logic [1:0] lo,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[lo*8 +: 8];
    h = lo[1] ? w[31:16] : w[15:0];
    case (fn)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'd0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'd0, h};
      3'b010:  return w;
      default: return 32'd0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid   = 1'b0;
    ex_rd      = 5'd0;
    ex_wen     = 1'b0;
    ex_result  = 32'd0;
    ex_is_load = 1'b0;
    ex_load_fn = 3'd0;
    ex_addr_lo = 2'd0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'd0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    n_vec++;
    if ({reg_wen, wb_done, err_misalign, err_timeout} !== 4'b0
        || waddr !== 5'd0 || wdata !== 32'd0) begin
      n_err++;
      $display("FAIL reset_outs: wen=%b done=%b em=%b et=%b a=%0d d=%h want 0",
               reg_wen, wb_done, err_misalign, err_timeout, waddr, wdata);
    end
    n_vec++;
    if (ex_ready !== 1'b1 || mem_rready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_rdy: ex_ready=%b mem_rready=%b want 1/0",
               ex_ready, mem_rready);
    end
    #2 rst = 1'b0;
    tick();
  endtask

  task automatic test_alu_stream();
    exp_t e;
    for (int i = 1; i <= 3; i++) begin
      ex_valid  = 1'b1;
      ex_wen    = 1'b1;
      ex_rd     = 5'(i);
      ex_result = 32'(i * 32'h11);
      sbq.push_back('{1'b1, 5'(i), 32'(i * 32'h11)});
      n_vec++;
      if (ex_ready !== 1'b1) begin
        n_err++;
        $display("FAIL alu_ready%0d: got %b want 1", i, ex_ready);
      end
      tick();
      n_vec++;
      if (wb_done !== 1'b1 || sbq.size() == 0) begin
        n_err++;
        $display("FAIL alu_done%0d: got %b want 1", i, wb_done);
      end else begin
        e = sbq.pop_front();
        if (reg_wen !== e.wen || waddr !== e.a || wdata !== e.d) begin
          n_err++;
          $display("FAIL alu_wr%0d: got %b/%0d/%h want %b/%0d/%h",
                   i, reg_wen, waddr, wdata, e.wen, e.a, e.d);
        end
      end
    end
    idle_inputs();
    tick();
    n_vec++;
    if (reg_wen !== 1'b0 || wb_done !== 1'b0) begin
      n_err++;
      $display("FAIL alu_idle: wen=%b done=%b want 0/0", reg_wen, wb_done);
    end
  endtask

  task automatic test_load(input string nm, input logic [2:0] fn,
                           input logic [1:0] lo, input logic [31:0] w,
                           input logic [4:0] rd, input int gap);
    exp_t e;
    ex_valid   = 1'b1;
    ex_is_load = 1'b1;
    ex_wen     = 1'b1;
    ex_rd      = rd;
    ex_load_fn = fn;
    ex_addr_lo = lo;
    ex_result  = 32'hDEAD_BEEF;
    sbq.push_back('{1'b1, rd, ld_model(fn, lo, w)});
    tick();
    idle_inputs();
    n_vec++;
    if (ex_ready !== 1'b0 || mem_rready !== 1'b1 || wb_done !== 1'b0) begin
      n_err++;
      $display("FAIL %s_wait: rdy=%b rr=%b done=%b want 0/1/0",
               nm, ex_ready, mem_rready, wb_done);
    end
    repeat (gap) tick();
    mem_rvalid = 1'b1;
    mem_rdata  = w;
    tick();
    idle_inputs();
    n_vec++;
    if (wb_done !== 1'b1 || sbq.size() == 0) begin
      n_err++;
      $display("FAIL %s_done: got %b want 1", nm, wb_done);
    end else begin
      e = sbq.pop_front();
      if (reg_wen !== e.wen || waddr !== e.a || wdata !== e.d
          || ex_ready !== 1'b1) begin
        n_err++;
        $display("FAIL %s_wr: got %b/%0d/%h rdy=%b want %b/%0d/%h rdy=1",
                 nm, reg_wen, waddr, wdata, ex_ready, e.wen, e.a, e.d);
      end
    end
    tick();
  endtask

  task automatic test_misalign();
    ex_valid   = 1'b1;
    ex_is_load = 1'b1;
    ex_wen     = 1'b1;
    ex_rd      = 5'd6;
    ex_load_fn = 3'b010;
    ex_addr_lo = 2'd1;
    tick();
    idle_inputs();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1234_5678;
    tick();
    idle_inputs();
    n_vec++;
    if (err_misalign !== 1'b1 || reg_wen !== 1'b0 || wb_done !== 1'b1) begin
      n_err++;
      $display("FAIL mis_lw: em=%b wen=%b done=%b want 1/0/1",
               err_misalign, reg_wen, wb_done);
    end
    ex_valid  = 1'b1;
    ex_wen    = 1'b1;
    ex_rd     = 5'd5;
    ex_result = 32'd7;
    tick();
    idle_inputs();
    n_vec++;
    if (reg_wen !== 1'b1 || waddr !== 5'd5 || wdata !== 32'd7
        || err_misalign !== 1'b1) begin
      n_err++;
      $display("FAIL mis_after: got %b/%0d/%h em=%b want 1/5/7 em=1",
               reg_wen, waddr, wdata, err_misalign);
    end
    tick();
  endtask

  task automatic test_timeout();
    ex_valid   = 1'b1;
    ex_is_load = 1'b1;
    ex_wen     = 1'b1;
    ex_rd      = 5'd9;
    ex_load_fn = 3'b010;
    ex_addr_lo = 2'd0;
    tick();
    idle_inputs();
    repeat (7) tick();
    n_vec++;
    if (err_timeout !== 1'b0 || wb_done !== 1'b0 || ex_ready !== 1'b0) begin
      n_err++;
      $display("FAIL to_early: et=%b done=%b rdy=%b want 0/0/0",
               err_timeout, wb_done, ex_ready);
    end
    tick();
    n_vec++;
    if (err_timeout !== 1'b1 || wb_done !== 1'b1 || reg_wen !== 1'b0
        || ex_ready !== 1'b1) begin
      n_err++;
      $display("FAIL to_fire: et=%b done=%b wen=%b rdy=%b want 1/1/0/1",
               err_timeout, wb_done, reg_wen, ex_ready);
    end
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hAAAA_AAAA;
    tick();
    idle_inputs();
    n_vec++;
    if (reg_wen !== 1'b0 || wb_done !== 1'b0 || mem_rready !== 1'b0) begin
      n_err++;
      $display("FAIL to_late: wen=%b done=%b rr=%b want 0/0/0",
               reg_wen, wb_done, mem_rready);
    end
    tick();
  endtask

  task automatic test_rd0();
    ex_valid  = 1'b1;
    ex_wen    = 1'b1;
    ex_rd     = 5'd0;
    ex_result = 32'h5555_5555;
    tick();
    idle_inputs();
    n_vec++;
    if (wb_done !== 1'b1 || reg_wen !== 1'b0) begin
      n_err++;
      $display("FAIL rd0: done=%b wen=%b want 1/0", wb_done, reg_wen);
    end
    tick();
  endtask

  task automatic test_reset_wait();
    ex_valid   = 1'b1;
    ex_is_load = 1'b1;
    ex_wen     = 1'b1;
    ex_rd      = 5'd12;
    ex_load_fn = 3'b010;
    tick();
    idle_inputs();
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({reg_wen, wb_done, err_misalign, err_timeout} !== 4'b0
        || waddr !== 5'd0 || wdata !== 32'd0 || ex_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rst_wait: wen=%b done=%b em=%b et=%b a=%0d d=%h rdy=%b",
               reg_wen, wb_done, err_misalign, err_timeout, waddr, wdata,
               ex_ready);
    end
    tick();
    #2 rst = 1'b0;
    tick();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0F0F_0F0F;
    tick();
    idle_inputs();
    n_vec++;
    if (reg_wen !== 1'b0 || wb_done !== 1'b0) begin
      n_err++;
      $display("FAIL rst_late: wen=%b done=%b want 0/0", reg_wen, wb_done);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_alu_stream();
    test_load("lb",  3'b000, 2'd3, 32'h80FF_1234, 5'd4, 1);
    test_load("lhu", 3'b101, 2'd2, 32'hBEEF_0001, 5'd7, 0);
    test_load("lh",  3'b001, 2'd2, 32'hBEEF_0001, 5'd8, 2);
    test_load("lbu", 3'b100, 2'd1, 32'h0000_9A00, 5'd10, 0);
    test_load("lw",  3'b010, 2'd0, 32'hCAFE_F00D, 5'd11, 1);
    test_misalign();
    test_rd0();
    test_timeout();
    test_reset_wait();
    n_vec++;
    if (sbq.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: %0d entries left want 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
